// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline.
// PC-select encoding, fetch FSM states, instruction width and NOP.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select: pc+4, branch, jump, jump-register, plus alignment.
// In: pc, pc_src, targets, jump index, pc4_hi. Out: pc_plus4, next_pc, redirect, misaligned.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] pc,
  input  pc_src_t            pc_src,
  input  logic [INSTR_W-1:0] branch_target,
  input  logic [25:0]        jump_index,
  input  logic [INSTR_W-1:0] jr_target,
  input  logic [3:0]         pc4_hi,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic [INSTR_W-1:0] next_pc,
  output logic               redirect,
  output logic               misaligned
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      (pc_src == PC_SEQ):    next_pc = pc_plus4;
      (pc_src == PC_BRANCH): next_pc = branch_target;
      (pc_src == PC_JUMP):   next_pc = {pc4_hi, jump_index, 2'b00};
      (pc_src == PC_JR):     next_pc = jr_target;
    endcase
  end

  assign redirect   = (pc_src != PC_SEQ);
  assign misaligned = redirect && (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// IF stage: PC register, sync-ROM addressing and IF/ID register.
// In: clk, reset, stall, pc_src, targets, imem_rdata. Out: imem_*, pc, if_id_*, fetch_err.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_err
);

  import mips_pkg::*;

  fetch_state_t state;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        misaligned;

  next_pc_mux u_next_pc_mux (
    .pc            (pc),
    .pc_src        (pc_src_t'(pc_src)),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .pc4_hi        (if_id_pc4[31:28]),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

  // ROM address tracks what pc will hold after this edge, so
  // imem_rdata always belongs to the current pc.
  always_comb begin
    imem_addr = next_pc;
    imem_en   = 1'b1;
    if (reset) begin
      imem_addr = RESET_PC;
      imem_en   = 1'b1;
    end else if (state == HALT) begin
      imem_addr = pc;
      imem_en   = 1'b0;
    end else if (redirect && misaligned) begin
      imem_addr = pc;
      imem_en   = 1'b0;
    end else if (redirect) begin
      imem_addr = next_pc;
      imem_en   = 1'b1;
    end else if (stall) begin
      imem_addr = pc;
      imem_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (state == RUN) begin
      if (redirect && misaligned) begin
        state       <= HALT;
        fetch_err   <= 1'b1;
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (redirect) begin
        pc          <= next_pc;
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (!stall) begin
        pc          <= pc_plus4;
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the MIPS pipeline. Owns the program counter and the PCSrc next-PC mux.
- Drives the synchronous instruction memory and registers the fetched instruction, together with its PC+4, into the IF/ID pipeline register consumed by decode.
- Handles stall, control-flow redirect with flush, and halts fetch on a misaligned redirect target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on if_id_instr when the entry is invalid (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC, memory output and IF/ID
- pc_src  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register
- branch_target  in  32  resolved branch address
- jump_index  in  26  instr_index field of the J-type instruction currently in ID
- jr_target  in  32  register value for jr/jalr
- imem_addr  out  32  next-PC address to the synchronous ROM
- imem_en  out  1  ROM read enable; ROM registers data only when high
- imem_rdata  in  32  ROM data; equals mem[address sampled at last enabled edge]
- pc  out  32  address of the instruction currently on imem_rdata
- if_id_instr  out  32  registered instruction
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID entry holds a real instruction
- fetch_err  out  1  sticky misaligned-target flag

Behaviour:
- One clock domain. All state updates on the rising edge of clk. reset is synchronous and active-high; it wins over every other input.
- Reset values:
  - pc = RESET_PC
  - if_id_instr = NOP_INSTR
  - if_id_pc4 = 0
  - if_id_valid = 0
  - fetch_err = 0
  - state = RUN
- While reset is high: imem_addr = RESET_PC and imem_en = 1, so imem_rdata = mem[RESET_PC] in the first cycle after reset is released.
- pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Next-PC mux (combinational):
  - 00 -> pc_plus4
  - 01 -> branch_target
  - 10 -> {if_id_pc4[31:28], jump_index, 2'b00}
  - 11 -> jr_target
- redirect = (pc_src != 00). misaligned = redirect && next_pc[1:0] != 0.
- imem_addr = next_pc, except when stalled without redirect, where imem_addr = pc.
- Memory/PC alignment: pc always equals the address whose data sits on imem_rdata. Fetch latency is one cycle from imem_addr to imem_rdata. IF/ID captures it at the following edge.
- State RUN, per edge, in priority order:
  1. redirect && misaligned:
     - state -> HALT, fetch_err <= 1
     - if_id_valid <= 0, if_id_instr <= NOP_INSTR
     - pc unchanged
  2. redirect (redirect takes priority over stall):
     - pc <= next_pc
     - if_id_valid <= 0, if_id_instr <= NOP_INSTR (flush of the wrong-path fetch; no delay slot)
     - imem_en = 1
  3. stall:
     - imem_en = 0; pc and all IF/ID outputs hold
  4. otherwise:
     - pc <= pc_plus4
     - if_id_instr <= imem_rdata, if_id_pc4 <= pc_plus4, if_id_valid <= 1
     - imem_en = 1
- State HALT:
  - imem_en = 0; pc holds
  - if_id_valid = 0, if_id_instr = NOP_INSTR
  - all inputs except reset ignored; only reset exits to RUN
- Back-to-back redirects: each one re-flushes; a single valid instruction appears only after one non-redirect, non-stall cycle.
- Reset mid-stall or mid-redirect: reset values apply at that edge regardless.

Decomposition:
- Shared package mips_pkg:
  - typedef enum pc_src_t {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR}
  - fetch_state_t {RUN, HALT}
  - constant NOP_INSTR
  - localparam INSTR_W = 32
- Sub-module next_pc_mux: combinational, computes pc_plus4, next_pc and misaligned.
- instr_fetch holds the PC register, the FSM and the IF/ID register.

Test Plan:
1. Reset, then free-run, ROM mem[0]=0x2008_0005, mem[4]=0x2009_0007:
   - first post-reset edge: if_id_instr=0x2008_0005, if_id_pc4=4, if_id_valid=1
   - next edge: if_id_instr=0x2009_0007, if_id_pc4=8
2. Stall held 3 cycles at pc=8:
   - imem_en=0, pc stays 8, IF/ID unchanged, no instruction skipped or duplicated after release
3. pc_src=01, branch_target=0x40 while pc=0x10:
   - next edge: pc=0x40, if_id_valid=0
   - following edge: if_id_pc4=0x44, instruction = mem[0x40]
4. pc_src=10, jump_index=0x000_0100, if_id_pc4=0x1000_0008:
   - pc becomes 0x1000_0400
5. pc_src=11, jr_target=0x0000_0022:
   - fetch_err=1, state HALT, imem_en=0, if_id_valid stays 0 for 10 cycles
   - reset restores pc=RESET_PC and fetch_err=0
6. Redirect and stall asserted together; separately, pc=0xFFFF_FFFC running sequentially:
   - redirect wins (pc=target, flush)
   - the sequential fetch wraps pc to 0x0000_0000, if_id_pc4=0
